// File: rtl/cass_pkg.sv
// Shared cassette-interface types and default timing constants.
// Used by the input decoder and by the codec-side encoder.
package cass_pkg;

   typedef enum logic [1:0] {
      HUNT,
      SYNC,
      SHIFT,
      STOP
   } state_t;

   typedef enum logic [1:0] {
      BIT0,
      BIT1,
      INVALID
   } bit_cls_t;

   localparam int CASS_FILT_CYC   = 64;
   localparam int CASS_PRESCALE   = 192;
   localparam int CASS_MIN_PER    = 24;
   localparam int CASS_THRESH     = 72;
   localparam int CASS_MAX_PER    = 144;
   localparam int CASS_LEADER_MIN = 32;

   function automatic bit_cls_t classify(
      input logic [7:0] c,
      input logic [7:0] min_per,
      input logic [7:0] thresh
   );
      if (c < min_per)
         return INVALID;
      else if (c < thresh)
         return BIT1;
      else
         return BIT0;
   endfunction

endpackage

// File: rtl/cass_glitch_filter.sv
// Synchronizer plus stability filter for the raw cassette level.
// The level follows the input only after FILT_CYC stable clocks.
module cass_glitch_filter #(
   parameter int FILT_CYC = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic din,
   output logic level
);

   localparam int CW = $clog2(FILT_CYC + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (clr || sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT_CYC - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cass_in_decoder.sv
// Cassette-input byte decoder: period classifier, framing FSM
// and valid/ack byte handoff to the CPU-side port latch.
module cass_in_decoder
   import cass_pkg::*;
#(
   parameter int FILT_CYC   = CASS_FILT_CYC,
   parameter int PRESCALE   = CASS_PRESCALE,
   parameter int MIN_PER    = CASS_MIN_PER,
   parameter int THRESH     = CASS_THRESH,
   parameter int MAX_PER    = CASS_MAX_PER,
   parameter int LEADER_MIN = CASS_LEADER_MIN
) (
   input  logic       iCLK_18_4,
   input  logic       iRST_N,
   input  logic       iCASS_IN,
   input  logic       iENABLE,
   input  logic       iDATA_ACK,
   output logic [7:0] oDATA,
   output logic       oDATA_VALID,
   output logic       oCARRIER,
   output logic       oFRAME_ERR,
   output logic       oOVERRUN
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int OW = $clog2(LEADER_MIN + 1);

   logic          filt;
   logic          filt_d;
   logic          rise;
   logic [PW-1:0] pre;
   logic [7:0]    per;
   logic          ref_set;
   logic          tick;
   logic          timeout;
   logic          ev;
   bit_cls_t      cls;

   state_t        state;
   state_t        state_nx;
   logic [OW-1:0] ones;
   logic [OW-1:0] ones_nx;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nx;
   logic [7:0]    shreg;
   logic [7:0]    shreg_nx;
   logic          byte_done;
   logic          frame_err_nx;

   cass_glitch_filter #(
      .FILT_CYC(FILT_CYC)
   ) u_filt (
      .clk  (iCLK_18_4),
      .rst_n(iRST_N),
      .clr  (!iENABLE),
      .din  (iCASS_IN),
      .level(filt)
   );

   assign rise    = filt && !filt_d;
   assign tick    = (pre == PW'(PRESCALE - 1));
   // an edge in the same clock as the timeout tick wins
   assign timeout = tick && !rise
                 && (per == 8'(MAX_PER - 1));
   assign ev      = (rise && ref_set) || timeout;
   assign cls     = timeout ? INVALID
                  : classify(per, 8'(MIN_PER), 8'(THRESH));
   assign oCARRIER = (state != HUNT);

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         filt_d  <= 1'b0;
         pre     <= '0;
         per     <= '0;
         ref_set <= 1'b0;
      end else begin
         filt_d <= filt;
         if (!iENABLE || rise) begin
            pre <= '0;
            per <= '0;
         end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick && per != 8'hFF)
               per <= per + 8'd1;
         end
         if (!iENABLE)
            ref_set <= 1'b0;
         else if (rise)
            ref_set <= !ref_set || (cls != INVALID);
         else if (timeout)
            ref_set <= 1'b0;
      end
   end

   always_comb begin
      state_nx     = state;
      ones_nx      = ones;
      bit_idx_nx   = bit_idx;
      shreg_nx     = shreg;
      byte_done    = 1'b0;
      frame_err_nx = 1'b0;
      if (ev) begin
         unique case (state)
            HUNT: begin
               if (cls != BIT1) begin
                  ones_nx = '0;
               end else if (ones == OW'(LEADER_MIN - 1)) begin
                  ones_nx  = '0;
                  state_nx = SYNC;
               end else begin
                  ones_nx = ones + 1'b1;
               end
            end
            SYNC: begin
               if (cls == BIT0) begin
                  state_nx   = SHIFT;
                  bit_idx_nx = '0;
               end else if (cls == INVALID) begin
                  state_nx = HUNT;
               end
            end
            SHIFT: begin
               if (cls == INVALID) begin
                  state_nx     = HUNT;
                  frame_err_nx = 1'b1;
               end else begin
                  shreg_nx   = {cls == BIT1, shreg[7:1]};
                  bit_idx_nx = bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state_nx = STOP;
               end
            end
            STOP: begin
               if (cls == BIT1) begin
                  byte_done = 1'b1;
                  state_nx  = SYNC;
               end else begin
                  state_nx     = HUNT;
                  frame_err_nx = 1'b1;
               end
            end
            default: state_nx = HUNT;
         endcase
      end
      // disabling abandons any frame silently
      if (!iENABLE) begin
         state_nx     = HUNT;
         ones_nx      = '0;
         bit_idx_nx   = '0;
         byte_done    = 1'b0;
         frame_err_nx = 1'b0;
      end
   end

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         state       <= HUNT;
         ones        <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         oDATA       <= '0;
         oDATA_VALID <= 1'b0;
         oFRAME_ERR  <= 1'b0;
         oOVERRUN    <= 1'b0;
      end else begin
         state      <= state_nx;
         ones       <= ones_nx;
         bit_idx    <= bit_idx_nx;
         shreg      <= shreg_nx;
         oFRAME_ERR <= frame_err_nx;
         oOVERRUN   <= byte_done && oDATA_VALID
                    && !iDATA_ACK;
         if (byte_done && (!oDATA_VALID || iDATA_ACK)) begin
            oDATA       <= shreg;
            oDATA_VALID <= 1'b1;
         end else if (iDATA_ACK) begin
            oDATA_VALID <= 1'b0;
         end
      end
   end

endmodule
